// File: rtl/phy_pkg.sv
// Shared PHY constants for the TX mux and the RX demux: lane width, idle fill
// byte, lane counts and slot-phase encoding.
package phy_pkg;

    localparam int DW          = 8;
    localparam int N_PAR_LANES = 4;
    localparam int N_SER_LANES = 2;

    localparam logic [7:0] IDLE_BYTE = 8'hBC;

    localparam logic PH_EVEN = 1'b0;
    localparam logic PH_ODD  = 1'b1;

endpackage

// File: rtl/mux_l1_slice.sv
// One 2:1 time-slice of the first-level TX mux: even lane passes straight to the
// output register, odd lane is parked in a hold register for the next slot.
module mux_l1_slice
    import phy_pkg::*;
#(
    parameter int             DW        = phy_pkg::DW,
    parameter bit             IDLE_FILL = 1'b0,
    parameter logic [DW-1:0]  IDLE_VAL  = {DW{1'b0}}
) (
    input  logic          clk_2f,
    input  logic          rst_n,
    input  logic          srst,
    input  logic          phase,
    input  logic [DW-1:0] data_even,
    input  logic          valid_even,
    input  logic [DW-1:0] data_odd,
    input  logic          valid_odd,
    output logic [DW-1:0] data_out,
    output logic          valid_out
);

    logic [DW-1:0] hold_data_r;
    logic          hold_valid_r;
    logic [DW-1:0] out_data_r;
    logic          out_valid_r;

    logic [DW-1:0] hold_data_nxt_s;
    logic          hold_valid_nxt_s;
    logic [DW-1:0] slot_data_s;
    logic          slot_valid_s;
    logic [DW-1:0] out_data_nxt_s;

    // Select the lane owning this slot and park the odd lane on the even edge
    always_comb begin
        hold_data_nxt_s  = hold_data_r;
        hold_valid_nxt_s = hold_valid_r;
        slot_data_s      = hold_data_r;
        slot_valid_s     = hold_valid_r;
        if (phase == PH_EVEN) begin
            hold_data_nxt_s  = data_odd;
            hold_valid_nxt_s = valid_odd;
            slot_data_s      = data_even;
            slot_valid_s     = valid_even;
        end else begin
            slot_data_s      = hold_data_r;
            slot_valid_s     = hold_valid_r;
        end
    end

    // An empty slot either keeps the previous byte or shows the idle pattern
    always_comb begin
        out_data_nxt_s = out_data_r;
        if (slot_valid_s) begin
            out_data_nxt_s = slot_data_s;
        end else if (IDLE_FILL) begin
            out_data_nxt_s = IDLE_VAL;
        end else begin
            out_data_nxt_s = out_data_r;
        end
    end

    // Hold and output registers
    always_ff @(posedge clk_2f or negedge rst_n) begin
        if (!rst_n) begin
            hold_data_r  <= {DW{1'b0}};
            hold_valid_r <= 1'b0;
            out_data_r   <= {DW{1'b0}};
            out_valid_r  <= 1'b0;
        end else if (srst) begin
            hold_data_r  <= {DW{1'b0}};
            hold_valid_r <= 1'b0;
            out_data_r   <= {DW{1'b0}};
            out_valid_r  <= 1'b0;
        end else begin
            hold_data_r  <= hold_data_nxt_s;
            hold_valid_r <= hold_valid_nxt_s;
            out_data_r   <= out_data_nxt_s;
            out_valid_r  <= slot_valid_s;
        end
    end

    assign data_out  = out_data_r;
    assign valid_out = out_valid_r;

endmodule

// File: rtl/mux_l1_tx.sv
// TX first-level lane mux: four frame-rate byte lanes onto two double-rate lanes.
// Define MUX_L1_IDLE_FILL_EN to send IDLE_BYTE in empty slots instead of holding.
module mux_l1_tx
    import phy_pkg::*;
#(
    parameter int                 DW        = phy_pkg::DW,
    parameter logic [DW-1:0]      IDLE_BYTE = phy_pkg::IDLE_BYTE
) (
    input  logic          clk_2f,
    input  logic          reset_L,
    input  logic [DW-1:0] data_0,
    input  logic [DW-1:0] data_1,
    input  logic [DW-1:0] data_2,
    input  logic [DW-1:0] data_3,
    input  logic          valid_0,
    input  logic          valid_1,
    input  logic          valid_2,
    input  logic          valid_3,
    output logic [DW-1:0] data_00,
    output logic [DW-1:0] data_11,
    output logic          valid_00,
    output logic          valid_11,
    output logic          phase
);

`ifdef MUX_L1_IDLE_FILL_EN
    localparam bit IDLE_FILL_EN = 1'b1;
`else
    localparam bit IDLE_FILL_EN = 1'b0;
`endif

    logic phase_r;
    logic srst_s;

    // No soft-reset source exists at this level; the slices still honour one
    assign srst_s = 1'b0;

    // Slot phase: first edge after reset is the even-lane load edge
    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            phase_r <= PH_EVEN;
        end else if (srst_s) begin
            phase_r <= PH_EVEN;
        end else begin
            phase_r <= ~phase_r;
        end
    end

    assign phase = phase_r;

    mux_l1_slice #(
        .DW        (DW),
        .IDLE_FILL (IDLE_FILL_EN),
        .IDLE_VAL  (IDLE_BYTE)
    ) u_slice_a (
        .clk_2f     (clk_2f),
        .rst_n      (reset_L),
        .srst       (srst_s),
        .phase      (phase_r),
        .data_even  (data_0),
        .valid_even (valid_0),
        .data_odd   (data_1),
        .valid_odd  (valid_1),
        .data_out   (data_00),
        .valid_out  (valid_00)
    );

    mux_l1_slice #(
        .DW        (DW),
        .IDLE_FILL (IDLE_FILL_EN),
        .IDLE_VAL  (IDLE_BYTE)
    ) u_slice_b (
        .clk_2f     (clk_2f),
        .rst_n      (reset_L),
        .srst       (srst_s),
        .phase      (phase_r),
        .data_even  (data_2),
        .valid_even (valid_2),
        .data_odd   (data_3),
        .valid_odd  (valid_3),
        .data_out   (data_11),
        .valid_out  (valid_11)
    );

endmodule

// File: tb/tb_mux_l1_tx.sv
// Directed plus randomized bench for mux_l1_tx against a frame-level model of the
// lane serialisation (expected streams built from the sampled frame contents).
module tb_mux_l1_tx;

    localparam logic [7:0] IDLE = 8'hBC;
`ifdef MUX_L1_IDLE_FILL_EN
    localparam bit FILL = 1'b1;
`else
    localparam bit FILL = 1'b0;
`endif

    logic       clk_2f = 1'b0;
    logic       reset_L;
    logic [7:0] data_0, data_1, data_2, data_3;
    logic       valid_0, valid_1, valid_2, valid_3;
    logic [7:0] data_00, data_11;
    logic       valid_00, valid_11;
    logic       phase;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: last byte shown on each serial lane
    logic [7:0] last_a, last_b;

    always #5 clk_2f = ~clk_2f;

    mux_l1_tx dut (
        .clk_2f   (clk_2f),
        .reset_L  (reset_L),
        .data_0   (data_0),
        .data_1   (data_1),
        .data_2   (data_2),
        .data_3   (data_3),
        .valid_0  (valid_0),
        .valid_1  (valid_1),
        .valid_2  (valid_2),
        .valid_3  (valid_3),
        .data_00  (data_00),
        .data_11  (data_11),
        .valid_00 (valid_00),
        .valid_11 (valid_11),
        .phase    (phase)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_2f);
        #1;
    endtask

    task automatic scramble_inputs();
        data_0  = 8'($urandom);
        data_1  = 8'($urandom);
        data_2  = 8'($urandom);
        data_3  = 8'($urandom);
        valid_0 = 1'($urandom);
        valid_1 = 1'($urandom);
        valid_2 = 1'($urandom);
        valid_3 = 1'($urandom);
    endtask

    // Expected byte for one serial slot given the lane's byte and valid
    function automatic logic [7:0] slot_byte(input logic [7:0] d, input logic v,
                                             input logic [7:0] last);
        if (v) return d;
        return FILL ? IDLE : last;
    endfunction

    // Present one frame at the even edge, then garbage during the odd slot
    task automatic frame(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3, input logic [3:0] v,
                         input bit poison);
        logic [7:0] ea, eb;
        check({tag, ".phase_even"}, {7'd0, phase}, 8'd0);
        data_0 = d0; data_1 = d1; data_2 = d2; data_3 = d3;
        {valid_3, valid_2, valid_1, valid_0} = v;
        tick();
        ea = slot_byte(d0, v[0], last_a);
        eb = slot_byte(d2, v[2], last_b);
        last_a = ea; last_b = eb;
        check({tag, ".a0"}, data_00, ea);
        check({tag, ".va0"}, {7'd0, valid_00}, {7'd0, v[0]});
        check({tag, ".b0"}, data_11, eb);
        check({tag, ".vb0"}, {7'd0, valid_11}, {7'd0, v[2]});
        check({tag, ".phase_odd"}, {7'd0, phase}, 8'd1);
        if (poison) begin
            data_0 = 8'hAA; data_1 = 8'hAA; data_2 = 8'hAA; data_3 = 8'hAA;
            {valid_3, valid_2, valid_1, valid_0} = ~v;
        end else begin
            scramble_inputs();
        end
        tick();
        ea = slot_byte(d1, v[1], last_a);
        eb = slot_byte(d3, v[3], last_b);
        last_a = ea; last_b = eb;
        check({tag, ".a1"}, data_00, ea);
        check({tag, ".va1"}, {7'd0, valid_00}, {7'd0, v[1]});
        check({tag, ".b1"}, data_11, eb);
        check({tag, ".vb1"}, {7'd0, valid_11}, {7'd0, v[3]});
    endtask

    initial begin
        reset_L = 1'b0;
        data_0 = 8'd0; data_1 = 8'd0; data_2 = 8'd0; data_3 = 8'd0;
        valid_0 = 1'b0; valid_1 = 1'b0; valid_2 = 1'b0; valid_3 = 1'b0;
        last_a = 8'd0; last_b = 8'd0;
        tick();
        tick();
        check("rst.a", data_00, 8'd0);
        check("rst.b", data_11, 8'd0);
        check("rst.v", {6'd0, valid_00, valid_11}, 8'd0);
        check("rst.phase", {7'd0, phase}, 8'd0);
        reset_L = 1'b1;

        frame("full", 8'h11, 8'h22, 8'h33, 8'h44, 4'b1111, 1'b0);
        frame("partial", 8'h11, 8'hFF, 8'h33, 8'h44, 4'b1101, 1'b0);
        frame("ph1_ignored", 8'h5A, 8'hC3, 8'h0F, 8'hF0, 4'b1111, 1'b1);
        frame("lane_b_idle", 8'h01, 8'h02, 8'h03, 8'h04, 4'b0011, 1'b1);

        for (int k = 0; k < 16; k++) begin
            frame($sformatf("stream%0d", k), 8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2),
                  8'(4 * k + 3), 4'b1111, 1'b0);
        end

        // Reset in the middle of a frame: odd lanes of that frame must never appear
        data_0 = 8'h77; data_1 = 8'h88; data_2 = 8'h99; data_3 = 8'h66;
        {valid_3, valid_2, valid_1, valid_0} = 4'b1111;
        tick();
        check("mid.a0", data_00, 8'h77);
        #1;
        reset_L = 1'b0;
        #1;
        check("mid_rst.a", data_00, 8'd0);
        check("mid_rst.b", data_11, 8'd0);
        check("mid_rst.v", {6'd0, valid_00, valid_11}, 8'd0);
        check("mid_rst.phase", {7'd0, phase}, 8'd0);
        tick();
        check("mid_rst.hold_a", data_00, 8'd0);
        reset_L = 1'b1;
        last_a = 8'd0; last_b = 8'd0;
        frame("post_rst", 8'h00, 8'hE1, 8'hD2, 8'hC3, 4'b1110, 1'b0);

        for (int k = 0; k < 40; k++) begin
            frame($sformatf("rand%0d", k), 8'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
